// File: rtl/relu_sequencer.sv
// rtl/relu_sequencer.sv - walks an accumulator RAM, converts to fixed point with optional ReLU, writes activations
module relu_sequencer #(
    parameter int NUM_NEURONS   = 128,
    parameter int ACC_BITS      = 32,
    parameter int FP_TOTAL_BITS = 16,
    parameter int FP_FRAC_BITS  = 8,
    localparam int ADDR_BITS    = $clog2(NUM_NEURONS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     relu_en,
    output logic                     acc_rd_en,
    output logic [ADDR_BITS-1:0]     acc_rd_addr,
    input  logic [ACC_BITS-1:0]      acc_rd_data,
    output logic                     act_wr_en,
    output logic [ADDR_BITS-1:0]     act_wr_addr,
    output logic [FP_TOTAL_BITS-1:0] act_wr_data,
    output logic                     busy,
    output logic                     done,
    output logic                     sat_flag,
    output logic [ADDR_BITS:0]       zero_count
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_BITS-1:0]     LAST_ADDR = ADDR_BITS'(NUM_NEURONS - 1);
    localparam logic [ADDR_BITS-1:0]     ADDR_ONE  = ADDR_BITS'(1);
    localparam logic [ADDR_BITS:0]       ZC_ONE    = (ADDR_BITS + 1)'(1);
    localparam logic [FP_TOTAL_BITS-1:0] SAT_MAX   = {1'b0, {(FP_TOTAL_BITS - 1){1'b1}}};
    localparam logic [FP_TOTAL_BITS-1:0] SAT_MIN   = {1'b1, {(FP_TOTAL_BITS - 1){1'b0}}};

    state_t                     r_state;
    state_t                     w_next;
    logic                       r_rd_en;
    logic [ADDR_BITS-1:0]       r_rd_addr;
    logic                       r_pend;
    logic [ADDR_BITS-1:0]       r_pend_addr;
    logic                       r_wr_en;
    logic [ADDR_BITS-1:0]       r_wr_addr;
    logic [FP_TOTAL_BITS-1:0]   r_wr_data;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_sat;
    logic [ADDR_BITS:0]         r_zero_count;
    logic                       r_relu_mode;

    logic signed [ACC_BITS-1:0] w_shifted;
    logic [ACC_BITS-FP_TOTAL_BITS:0] w_hi;
    logic                       w_ovf;
    logic                       w_neg;
    logic                       w_zero;
    logic [FP_TOTAL_BITS-1:0]   w_sat_val;
    logic                       w_accept;

    // Bits above the target sign bit must all match the sign, otherwise the value is out of range.
    assign w_shifted = $signed(acc_rd_data) >>> FP_FRAC_BITS;
    assign w_hi      = w_shifted[ACC_BITS-1:FP_TOTAL_BITS-1];
    assign w_ovf     = !((&w_hi) || (~|w_hi));
    assign w_neg     = w_shifted[ACC_BITS-1];
    assign w_sat_val = w_ovf ? (w_neg ? SAT_MIN : SAT_MAX) : w_shifted[FP_TOTAL_BITS-1:0];
    assign w_zero    = r_relu_mode && w_neg;
    assign w_accept  = (r_state == S_IDLE) && start;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_READ;
            S_READ:  if (r_rd_addr == LAST_ADDR) w_next = S_DRAIN;
            S_DRAIN: if (r_wr_en && (r_wr_addr == LAST_ADDR)) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_en      <= 1'b0;
            r_rd_addr    <= '0;
            r_pend       <= 1'b0;
            r_pend_addr  <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_sat        <= 1'b0;
            r_zero_count <= '0;
            r_relu_mode  <= 1'b0;
        end else begin
            r_rd_en <= (w_next == S_READ);
            r_busy  <= (w_next == S_READ) || (w_next == S_DRAIN);
            r_done  <= (w_next == S_DONE);

            if (w_accept) begin
                r_rd_addr    <= '0;
                r_relu_mode  <= relu_en;
                r_sat        <= 1'b0;
                r_zero_count <= '0;
            end else if ((r_state == S_READ) && (w_next == S_READ)) begin
                r_rd_addr <= r_rd_addr + ADDR_ONE;
            end

            // r_pend marks the cycle in which RAM data for r_pend_addr is on acc_rd_data.
            r_pend      <= r_rd_en;
            r_pend_addr <= r_rd_addr;
            r_wr_en     <= r_pend;
            if (r_pend) begin
                r_wr_addr <= r_pend_addr;
                r_wr_data <= w_zero ? '0 : w_sat_val;
                if (w_ovf) r_sat <= 1'b1;
                if (w_zero) r_zero_count <= r_zero_count + ZC_ONE;
            end
        end
    end

    assign acc_rd_en   = r_rd_en;
    assign acc_rd_addr = r_rd_addr;
    assign act_wr_en   = r_wr_en;
    assign act_wr_addr = r_wr_addr;
    assign act_wr_data = r_wr_data;
    assign busy        = r_busy;
    assign done        = r_done;
    assign sat_flag    = r_sat;
    assign zero_count  = r_zero_count;

endmodule

// File: tb/tb_relu_sequencer.sv
// tb/tb_relu_sequencer.sv - directed self-checking bench for relu_sequencer with N=4
module tb_relu_sequencer;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        relu_en;
    logic        acc_rd_en;
    logic [1:0]  acc_rd_addr;
    logic [31:0] acc_rd_data = '0;
    logic        act_wr_en;
    logic [1:0]  act_wr_addr;
    logic [15:0] act_wr_data;
    logic        busy;
    logic        done;
    logic        sat_flag;
    logic [2:0]  zero_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:3];
    logic [15:0] exp_d [0:3];

    logic        o_rd_en   [0:31];
    logic [1:0]  o_rd_addr [0:31];
    logic        o_wr_en   [0:31];
    logic [1:0]  o_wr_addr [0:31];
    logic [15:0] o_wr_data [0:31];
    logic        o_busy    [0:31];
    logic        o_done    [0:31];

    relu_sequencer #(
        .NUM_NEURONS(N), .ACC_BITS(32), .FP_TOTAL_BITS(16), .FP_FRAC_BITS(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
        .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr), .acc_rd_data(acc_rd_data),
        .act_wr_en(act_wr_en), .act_wr_addr(act_wr_addr), .act_wr_data(act_wr_data),
        .busy(busy), .done(done), .sat_flag(sat_flag), .zero_count(zero_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (acc_rd_en) acc_rd_data <= mem[acc_rd_addr];

    // Cycle k of a run is the cycle whose start/relu_en come from smask[k]/rvec[k].
    task automatic do_run(input logic [31:0] smask, input logic [31:0] rvec, input int ncyc);
        @(posedge clk); #1;
        for (int k = 0; k < ncyc; k++) begin
            start   = smask[k];
            relu_en = rvec[k];
            @(negedge clk);
            o_rd_en[k]   = acc_rd_en;
            o_rd_addr[k] = acc_rd_addr;
            o_wr_en[k]   = act_wr_en;
            o_wr_addr[k] = act_wr_addr;
            o_wr_data[k] = act_wr_data;
            o_busy[k]    = busy;
            o_done[k]    = done;
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic load_basic();
        mem[0] = 32'h0001_8000; mem[1] = 32'hFFFF_8000;
        mem[2] = 32'h0000_0000; mem[3] = 32'h0000_0080;
    endtask

    task automatic load_sat();
        mem[0] = 32'h7FFF_0000; mem[1] = 32'h8000_0000;
        mem[2] = 32'h0000_0000; mem[3] = 32'h0000_0000;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; relu_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({acc_rd_en, act_wr_en, busy, done, sat_flag} !== 5'b0)
            $display("FAIL reset_strobes got=%b want=00000", {acc_rd_en, act_wr_en, busy, done, sat_flag});
        total++;
        if ({acc_rd_addr, act_wr_addr, act_wr_data, zero_count} !== 23'h0)
            $display("FAIL reset_values got=%h want=0", {acc_rd_addr, act_wr_addr, act_wr_data, zero_count});
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({acc_rd_en, busy, done} !== 3'b0)
            $display("FAIL idle_after_reset got=%b want=000", {acc_rd_en, busy, done});
    endtask

    task automatic test_relu_on();
        load_basic();
        exp_d[0] = 16'h0180; exp_d[1] = 16'h0000; exp_d[2] = 16'h0000; exp_d[3] = 16'h0000;
        do_run(32'h1, 32'hFFFF_FFFF, 10);
        for (int k = 0; k < 10; k++) begin
            logic e_rd, e_wr, e_busy, e_done;
            e_rd = (k >= 1) && (k <= N);
            e_wr = (k >= 3) && (k <= N + 2);
            e_busy = (k >= 1) && (k <= N + 2);
            e_done = (k == N + 3);
            total++;
            if (o_rd_en[k] !== e_rd) begin bad++; $display("FAIL relu_on_rd_en k=%0d got=%b want=%b", k, o_rd_en[k], e_rd); end
            if (e_rd) begin
                total++;
                if (o_rd_addr[k] !== 2'(k - 1)) begin bad++; $display("FAIL relu_on_rd_addr k=%0d got=%0d want=%0d", k, o_rd_addr[k], k - 1); end
            end
            total++;
            if (o_wr_en[k] !== e_wr) begin bad++; $display("FAIL relu_on_wr_en k=%0d got=%b want=%b", k, o_wr_en[k], e_wr); end
            if (e_wr) begin
                total++;
                if (o_wr_addr[k] !== 2'(k - 3) || o_wr_data[k] !== exp_d[k - 3]) begin
                    bad++;
                    $display("FAIL relu_on_write k=%0d got=%0d/%h want=%0d/%h", k, o_wr_addr[k], o_wr_data[k], k - 3, exp_d[k - 3]);
                end
            end
            total++;
            if (o_busy[k] !== e_busy) begin bad++; $display("FAIL relu_on_busy k=%0d got=%b want=%b", k, o_busy[k], e_busy); end
            total++;
            if (o_done[k] !== e_done) begin bad++; $display("FAIL relu_on_done k=%0d got=%b want=%b", k, o_done[k], e_done); end
        end
        total++;
        if (zero_count !== 3'd1 || sat_flag !== 1'b0) begin
            bad++; $display("FAIL relu_on_flags got zc=%0d sat=%b want zc=1 sat=0", zero_count, sat_flag);
        end
    endtask

    task automatic test_bypass();
        load_basic();
        exp_d[0] = 16'h0180; exp_d[1] = 16'hFF80; exp_d[2] = 16'h0000; exp_d[3] = 16'h0000;
        do_run(32'h1, 32'h0, 10);
        for (int k = 3; k < 7; k++) begin
            total++;
            if (o_wr_en[k] !== 1'b1 || o_wr_addr[k] !== 2'(k - 3) || o_wr_data[k] !== exp_d[k - 3]) begin
                bad++;
                $display("FAIL bypass_write k=%0d got=%b/%0d/%h want=1/%0d/%h", k, o_wr_en[k], o_wr_addr[k], o_wr_data[k], k - 3, exp_d[k - 3]);
            end
        end
        total++;
        if (zero_count !== 3'd0 || sat_flag !== 1'b0) begin
            bad++; $display("FAIL bypass_flags got zc=%0d sat=%b want zc=0 sat=0", zero_count, sat_flag);
        end
    endtask

    task automatic test_saturation();
        load_sat();
        exp_d[0] = 16'h7FFF; exp_d[1] = 16'h8000; exp_d[2] = 16'h0000; exp_d[3] = 16'h0000;
        do_run(32'h1, 32'h0, 10);
        for (int k = 3; k < 7; k++) begin
            total++;
            if (o_wr_data[k] !== exp_d[k - 3]) begin bad++; $display("FAIL sat_bypass_data k=%0d got=%h want=%h", k, o_wr_data[k], exp_d[k - 3]); end
        end
        total++;
        if (zero_count !== 3'd0 || sat_flag !== 1'b1) begin
            bad++; $display("FAIL sat_bypass_flags got zc=%0d sat=%b want zc=0 sat=1", zero_count, sat_flag);
        end
        exp_d[1] = 16'h0000;
        do_run(32'h1, 32'hFFFF_FFFF, 10);
        for (int k = 3; k < 7; k++) begin
            total++;
            if (o_wr_data[k] !== exp_d[k - 3]) begin bad++; $display("FAIL sat_relu_data k=%0d got=%h want=%h", k, o_wr_data[k], exp_d[k - 3]); end
        end
        total++;
        if (zero_count !== 3'd1 || sat_flag !== 1'b1) begin
            bad++; $display("FAIL sat_relu_flags got zc=%0d sat=%b want zc=1 sat=1", zero_count, sat_flag);
        end
        load_basic();
        do_run(32'h1, 32'h0, 10);
        total++;
        if (sat_flag !== 1'b0) begin bad++; $display("FAIL sat_clear_on_start got=%b want=0", sat_flag); end
    endtask

    task automatic test_start_ignored();
        int n_rd, n_wr, n_done;
        load_basic();
        exp_d[0] = 16'h0180; exp_d[1] = 16'h0000; exp_d[2] = 16'h0000; exp_d[3] = 16'h0000;
        do_run(32'h9, 32'h3, 14);
        n_rd = 0; n_wr = 0; n_done = 0;
        for (int k = 0; k < 14; k++) begin
            n_rd += int'(o_rd_en[k]);
            n_wr += int'(o_wr_en[k]);
            n_done += int'(o_done[k]);
        end
        total++;
        if (n_rd != 4 || n_wr != 4 || n_done != 1) begin
            bad++; $display("FAIL ignore_counts got rd=%0d wr=%0d done=%0d want 4/4/1", n_rd, n_wr, n_done);
        end
        for (int k = 3; k < 7; k++) begin
            total++;
            if (o_wr_data[k] !== exp_d[k - 3]) begin bad++; $display("FAIL ignore_captured_mode k=%0d got=%h want=%h", k, o_wr_data[k], exp_d[k - 3]); end
        end
        total++;
        if (zero_count !== 3'd1) begin bad++; $display("FAIL ignore_zc got=%0d want=1", zero_count); end
    endtask

    task automatic test_reset_midrun();
        load_sat();
        @(posedge clk); #1 start = 1'b1; relu_en = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (sat_flag !== 1'b1 || zero_count !== 3'd1 || act_wr_en !== 1'b1) begin
            bad++; $display("FAIL midrun_before_reset got sat=%b zc=%0d wr=%b want 1/1/1", sat_flag, zero_count, act_wr_en);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({acc_rd_en, act_wr_en, busy, done, sat_flag, zero_count, acc_rd_addr, act_wr_addr} !== 12'h0) begin
            bad++;
            $display("FAIL midrun_async_clear got=%h want=0", {acc_rd_en, act_wr_en, busy, done, sat_flag, zero_count, acc_rd_addr, act_wr_addr});
        end
        @(posedge clk); #1 reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            total++;
            if ({acc_rd_en, act_wr_en, done, busy} !== 4'b0) begin
                bad++; $display("FAIL midrun_quiet k=%0d got=%b want=0000", k, {acc_rd_en, act_wr_en, done, busy});
            end
        end
        load_basic();
        exp_d[0] = 16'h0180; exp_d[1] = 16'h0000; exp_d[2] = 16'h0000; exp_d[3] = 16'h0000;
        do_run(32'h1, 32'hFFFF_FFFF, 10);
        for (int k = 1; k < 5; k++) begin
            total++;
            if (o_rd_en[k] !== 1'b1 || o_rd_addr[k] !== 2'(k - 1)) begin
                bad++; $display("FAIL midrun_rerun_read k=%0d got=%b/%0d want=1/%0d", k, o_rd_en[k], o_rd_addr[k], k - 1);
            end
        end
        for (int k = 3; k < 7; k++) begin
            total++;
            if (o_wr_data[k] !== exp_d[k - 3]) begin bad++; $display("FAIL midrun_rerun_data k=%0d got=%h want=%h", k, o_wr_data[k], exp_d[k - 3]); end
        end
        total++;
        if (o_done[7] !== 1'b1 || zero_count !== 3'd1 || sat_flag !== 1'b0) begin
            bad++; $display("FAIL midrun_rerun_end got done=%b zc=%0d sat=%b want 1/1/0", o_done[7], zero_count, sat_flag);
        end
    endtask

    task automatic test_back_to_back();
        load_basic();
        do_run(32'h181, 32'hFFFF_FFFF, 18);
        for (int k = 0; k < 18; k++) begin
            logic e_busy, e_done, e_rd;
            e_busy = ((k >= 1) && (k <= 6)) || ((k >= 9) && (k <= 14));
            e_done = (k == 7) || (k == 15);
            e_rd   = ((k >= 1) && (k <= 4)) || ((k >= 9) && (k <= 12));
            total++;
            if (o_busy[k] !== e_busy || o_done[k] !== e_done || o_rd_en[k] !== e_rd) begin
                bad++;
                $display("FAIL b2b_cycle k=%0d got busy=%b done=%b rd=%b want %b/%b/%b", k, o_busy[k], o_done[k], o_rd_en[k], e_busy, e_done, e_rd);
            end
            if (k >= 9 && k <= 12) begin
                total++;
                if (o_rd_addr[k] !== 2'(k - 9)) begin bad++; $display("FAIL b2b_rd_addr k=%0d got=%0d want=%0d", k, o_rd_addr[k], k - 9); end
            end
        end
        do_run(32'h81, 32'hFFFF_FFFF, 12);
        for (int k = 8; k < 12; k++) begin
            total++;
            if (o_rd_en[k] !== 1'b0 || o_busy[k] !== 1'b0) begin
                bad++; $display("FAIL done_cycle_start k=%0d got rd=%b busy=%b want 0/0", k, o_rd_en[k], o_busy[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_relu_on();
        test_bypass();
        test_saturation();
        test_start_ignored();
        test_reset_midrun();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
